// File: rtl/rc4_pkg.sv
// -----------------------------------------------------------------------------
// rc4_pkg
// Shared types and constants for the RC4 key-search controller.
//   state_e        : sequencer states (also exported on the debug state port)
//   s_sel_e        : S-memory port owner select
//   ASCII_LO/HI/SP : bounds of the accepted plaintext alphabet
//   is_plain_char  : 1 when a decrypted byte is lowercase a..z or space
// -----------------------------------------------------------------------------
package rc4_pkg;

  localparam int KEY_WIDTH_DEF = 24;

  localparam logic [7:0] ASCII_LO = 8'd97;   // 'a'
  localparam logic [7:0] ASCII_HI = 8'd122;  // 'z'
  localparam logic [7:0] ASCII_SP = 8'd32;   // ' '

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_INIT     = 3'd2,
    ST_KSA      = 3'd3,
    ST_PRGA     = 3'd4,
    ST_NEXT_KEY = 3'd5,
    ST_FOUND    = 3'd6,
    ST_FAIL     = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_INIT = 2'd1,
    SEL_KSA  = 2'd2,
    SEL_PRGA = 2'd3
  } s_sel_e;

  function automatic logic is_plain_char(input logic [7:0] c);
    return ((c >= ASCII_LO) && (c <= ASCII_HI)) || (c == ASCII_SP);
  endfunction

endpackage

// File: rtl/s_mem_mux.sv
// -----------------------------------------------------------------------------
// s_mem_mux
// Combinational 3-to-1 mux onto the single S-memory port. Only the engine
// named by sel reaches the RAM; SEL_NONE parks the port (no write, addr/data 0),
// so stray write enables from idle engines never corrupt S.
// Ports:
//   sel                      : owner select from the sequencer
//   init_/ksa_/prga_addr     : engine S addresses (8b)
//   init_/ksa_/prga_wrdata   : engine S write data (8b)
//   init_/ksa_/prga_wren     : engine S write enables
//   s_addr, s_wrdata, s_wren : to S RAM
// -----------------------------------------------------------------------------
module s_mem_mux
  import rc4_pkg::*;
(
  input  s_sel_e     sel,
  input  logic [7:0] init_addr,
  input  logic [7:0] init_wrdata,
  input  logic       init_wren,
  input  logic [7:0] ksa_addr,
  input  logic [7:0] ksa_wrdata,
  input  logic       ksa_wren,
  input  logic [7:0] prga_addr,
  input  logic [7:0] prga_wrdata,
  input  logic       prga_wren,
  output logic [7:0] s_addr,
  output logic [7:0] s_wrdata,
  output logic       s_wren
);

  always_comb begin
    s_addr   = 8'd0;
    s_wrdata = 8'd0;
    s_wren   = 1'b0;
    case (sel)
      SEL_INIT: begin
        s_addr   = init_addr;
        s_wrdata = init_wrdata;
        s_wren   = init_wren;
      end
      SEL_KSA: begin
        s_addr   = ksa_addr;
        s_wrdata = ksa_wrdata;
        s_wren   = ksa_wren;
      end
      SEL_PRGA: begin
        s_addr   = prga_addr;
        s_wrdata = prga_wrdata;
        s_wren   = prga_wren;
      end
      default: begin
        s_addr   = 8'd0;
        s_wrdata = 8'd0;
        s_wren   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// -----------------------------------------------------------------------------
// rc4_key_search_ctrl
// Sequencer for the RC4 key search. For every candidate key it re-arms the
// three phase engines, then runs S-init, KSA and PRGA in order, owning the
// single S-memory port. Decrypted bytes are watched during PRGA; the first
// byte outside {a..z, space} rejects the key. Search ends on a passing key
// (FOUND) or after KEY_LAST has been rejected (FAIL).
//
// Engine protocol: *_start is a level enable held for the whole phase; the
// engine raises *_done (level) when finished and keeps it until re-armed
// through phase_rst_n. A phase advances on the first cycle its done is
// sampled high. dec_wren qualifies dec_wrdata: one byte per cycle it is high.
//
// Ports:
//   clk, reset                : clock, async active-low reset
//   start                     : pulse; begins a search at key 0 (ignored while busy)
//   busy, done_flag, found    : search status (registered)
//   key                       : current/final candidate key (registered)
//   phase_rst_n               : engine re-arm, low in ARM and while reset is low
//   init_/ksa_/prga_start     : phase enables (registered)
//   init_/ksa_/prga_done      : phase done flags
//   init_/ksa_/prga_addr/wrdata/wren : engine S-port requests
//   s_addr, s_wrdata, s_wren  : S RAM port
//   dec_wren, dec_wrdata      : monitored PRGA plaintext writes
//   dbg_state                 : current sequencer state
// -----------------------------------------------------------------------------
module rc4_key_search_ctrl
  import rc4_pkg::*;
#(
  parameter int                   KEY_WIDTH  = KEY_WIDTH_DEF,
  parameter logic [KEY_WIDTH-1:0] KEY_LAST   = KEY_WIDTH'(24'h3FFFFF),
  parameter int                   RST_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done_flag,
  output logic                 found,
  output logic [KEY_WIDTH-1:0] key,
  output logic                 phase_rst_n,
  output logic                 init_start,
  output logic                 ksa_start,
  output logic                 prga_start,
  input  logic                 init_done,
  input  logic                 ksa_done,
  input  logic                 prga_done,
  input  logic [7:0]           init_addr,
  input  logic [7:0]           ksa_addr,
  input  logic [7:0]           prga_addr,
  input  logic [7:0]           init_wrdata,
  input  logic [7:0]           ksa_wrdata,
  input  logic [7:0]           prga_wrdata,
  input  logic                 init_wren,
  input  logic                 ksa_wren,
  input  logic                 prga_wren,
  output logic [7:0]           s_addr,
  output logic [7:0]           s_wrdata,
  output logic                 s_wren,
  input  logic                 dec_wren,
  input  logic [7:0]           dec_wrdata,
  output state_e               dbg_state
);

  localparam logic [3:0] ARM_LAST = 4'(RST_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [3:0]             arm_cnt_q, arm_cnt_d;
  logic                   busy_q, done_q, found_q;
  logic                   init_start_q, ksa_start_q, prga_start_q;
  logic                   byte_bad;
  s_sel_e                 sel;

  assign byte_bad = dec_wren && !is_plain_char(dec_wrdata);

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    arm_cnt_d = arm_cnt_q;
    case (state_q)
      ST_IDLE, ST_FOUND, ST_FAIL: begin
        if (start) begin
          state_d   = ST_ARM;
          key_d     = '0;
          arm_cnt_d = '0;
        end
      end
      ST_ARM: begin
        if (arm_cnt_q == ARM_LAST) begin
          state_d   = ST_INIT;
          arm_cnt_d = '0;
        end else begin
          arm_cnt_d = arm_cnt_q + 4'd1;
        end
      end
      ST_INIT: if (init_done) state_d = ST_KSA;
      ST_KSA:  if (ksa_done)  state_d = ST_PRGA;
      ST_PRGA: begin
        // A bad byte in the same cycle as prga_done still rejects the key.
        if (byte_bad)       state_d = ST_NEXT_KEY;
        else if (prga_done) state_d = ST_FOUND;
      end
      ST_NEXT_KEY: begin
        if (key_q == KEY_LAST) begin
          state_d = ST_FAIL;
        end else begin
          state_d   = ST_ARM;
          key_d     = key_q + KEY_WIDTH'(1);
          arm_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status and enables are registered from the next state so they line up
  // with the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      key_q        <= '0;
      arm_cnt_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      found_q      <= 1'b0;
      init_start_q <= 1'b0;
      ksa_start_q  <= 1'b0;
      prga_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      arm_cnt_q    <= arm_cnt_d;
      busy_q       <= (state_d == ST_ARM) || (state_d == ST_INIT) || (state_d == ST_KSA) ||
                      (state_d == ST_PRGA) || (state_d == ST_NEXT_KEY);
      done_q       <= (state_d == ST_FOUND) || (state_d == ST_FAIL);
      found_q      <= (state_d == ST_FOUND);
      init_start_q <= (state_d == ST_INIT);
      ksa_start_q  <= (state_d == ST_KSA);
      prga_start_q <= (state_d == ST_PRGA);
    end
  end

  always_comb begin
    sel = SEL_NONE;
    case (state_q)
      ST_INIT: sel = SEL_INIT;
      ST_KSA:  sel = SEL_KSA;
      ST_PRGA: sel = SEL_PRGA;
      default: sel = SEL_NONE;
    endcase
  end

  s_mem_mux u_s_mem_mux (
    .sel         (sel),
    .init_addr   (init_addr),
    .init_wrdata (init_wrdata),
    .init_wren   (init_wren),
    .ksa_addr    (ksa_addr),
    .ksa_wrdata  (ksa_wrdata),
    .ksa_wren    (ksa_wren),
    .prga_addr   (prga_addr),
    .prga_wrdata (prga_wrdata),
    .prga_wren   (prga_wren),
    .s_addr      (s_addr),
    .s_wrdata    (s_wrdata),
    .s_wren      (s_wren)
  );

  // Combinational so engines drop into reset together with the chip reset.
  assign phase_rst_n = reset && (state_q != ST_ARM);

  assign busy       = busy_q;
  assign done_flag  = done_q;
  assign found      = found_q;
  assign key        = key_q;
  assign init_start = init_start_q;
  assign ksa_start  = ksa_start_q;
  assign prga_start = prga_start_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
module tb_rc4_key_search_ctrl;
  import rc4_pkg::*;

  localparam int KW = 24;
  localparam int W  = KW + 1;
  localparam int PRGA_LEN = 32;
  localparam int BUDGET = 3000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          start = 1'b0;
  logic          busy, done_flag, found, phase_rst_n;
  logic [KW-1:0] key;
  logic          init_start, ksa_start, prga_start;
  logic          init_done, ksa_done, prga_done;
  logic [7:0]    init_addr, ksa_addr, prga_addr;
  logic [7:0]    init_wrdata, ksa_wrdata, prga_wrdata;
  logic          init_wren, ksa_wren, prga_wren;
  logic [7:0]    s_addr, s_wrdata;
  logic          s_wren;
  logic          dec_wren;
  logic [7:0]    dec_wrdata;
  state_e        dbg_state;

  rc4_key_search_ctrl #(.KEY_WIDTH(KW), .KEY_LAST(24'd3), .RST_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done_flag(done_flag), .found(found), .key(key),
    .phase_rst_n(phase_rst_n),
    .init_start(init_start), .ksa_start(ksa_start), .prga_start(prga_start),
    .init_done(init_done), .ksa_done(ksa_done), .prga_done(prga_done),
    .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
    .init_wrdata(init_wrdata), .ksa_wrdata(ksa_wrdata), .prga_wrdata(prga_wrdata),
    .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .dec_wren(dec_wren), .dec_wrdata(dec_wrdata),
    .dbg_state(dbg_state)
  );

  // ---------------- scenario configuration ----------------
  int         bad_idx [4];
  logic [7:0] bad_val [4];
  bit         race    [4];
  bit         pat_sel [4];
  bit         init_force = 1'b0;
  bit         ksa_man_en = 1'b0;
  logic [KW-1:0] ksa_man_key = '0;
  logic [7:0] man_addr = 8'd0, man_wrdata = 8'd0;
  logic       man_wren = 1'b0;

  function automatic logic [7:0] prga_byte(input int k, input int c);
    logic [7:0] p;
    if (c == bad_idx[k]) return bad_val[k];
    if (pat_sel[k]) begin
      case (c % 4) 0: p = 8'd122; 1: p = 8'd32; 2: p = 8'd97; default: p = 8'd32; endcase
    end else begin
      case (c % 4) 0: p = 8'd97; 1: p = 8'd98; 2: p = 8'd99; default: p = 8'd32; endcase
    end
    return p;
  endfunction

  // ---------------- behavioural engines ----------------
  logic [7:0] i_cnt, k_cnt;
  int         p_cnt;
  logic       init_wren_m, ksa_wren_m, ksa_done_m;
  logic [7:0] init_addr_m, ksa_addr_m, ksa_wrdata_m;
  logic       ksa_manual;

  always @(posedge clk or negedge phase_rst_n) begin
    if (!phase_rst_n) begin
      i_cnt <= 8'd0; init_done <= 1'b0; init_wren_m <= 1'b0; init_addr_m <= 8'd0;
    end else begin
      init_wren_m <= 1'b0;
      if (init_start && !init_done) begin
        init_wren_m <= 1'b1;
        init_addr_m <= i_cnt;
        i_cnt <= i_cnt + 8'd1;
        if (i_cnt == 8'd3) init_done <= 1'b1;
      end
    end
  end
  assign init_wren   = init_wren_m | init_force;
  assign init_addr   = init_force ? 8'hAA : init_addr_m;
  assign init_wrdata = init_addr;

  always @(posedge clk or negedge phase_rst_n) begin
    if (!phase_rst_n) begin
      k_cnt <= 8'd0; ksa_done_m <= 1'b0; ksa_wren_m <= 1'b0; ksa_addr_m <= 8'd0; ksa_wrdata_m <= 8'd0;
    end else begin
      ksa_wren_m <= 1'b0;
      if (ksa_start && !ksa_done_m) begin
        ksa_wren_m   <= 1'b1;
        ksa_addr_m   <= k_cnt;
        ksa_wrdata_m <= ~k_cnt;
        k_cnt <= k_cnt + 8'd1;
        if (k_cnt == 8'd3) ksa_done_m <= 1'b1;
      end
    end
  end
  assign ksa_manual = ksa_man_en && (key == ksa_man_key);
  assign ksa_done   = ksa_manual ? 1'b0 : ksa_done_m;
  assign ksa_addr   = ksa_manual ? man_addr : ksa_addr_m;
  assign ksa_wrdata = ksa_manual ? man_wrdata : ksa_wrdata_m;
  assign ksa_wren   = ksa_manual ? man_wren : ksa_wren_m;

  always @(posedge clk or negedge phase_rst_n) begin
    if (!phase_rst_n) begin
      p_cnt <= 0; prga_done <= 1'b0; dec_wren <= 1'b0; dec_wrdata <= 8'd0;
      prga_wren <= 1'b0; prga_addr <= 8'd0; prga_wrdata <= 8'd0;
    end else begin
      dec_wren  <= 1'b0;
      prga_wren <= 1'b0;
      if (prga_start && !prga_done) begin
        if (p_cnt < PRGA_LEN) begin
          dec_wren    <= 1'b1;
          dec_wrdata  <= prga_byte(int'(key[1:0]), p_cnt);
          prga_wren   <= 1'b1;
          prga_addr   <= p_cnt[7:0];
          prga_wrdata <= p_cnt[7:0];
          p_cnt <= p_cnt + 1;
          if (race[key[1:0]] && p_cnt == PRGA_LEN - 1) prga_done <= 1'b1;
        end else begin
          prga_done <= 1'b1;
        end
      end
    end
  end

  // ---------------- monitors (ARM length, key stability) ----------------
  int arm_runs = 0, bad_len = 0, low_len = 0, key_glitch = 0;
  logic [KW-1:0] prev_key = '0;
  state_e        prev_state = ST_IDLE;

  always @(negedge clk) begin
    if (reset && !phase_rst_n) begin
      low_len = low_len + 1;
    end else if (low_len != 0) begin
      arm_runs = arm_runs + 1;
      if (low_len != 2) bad_len = bad_len + 1;
      low_len = 0;
    end
    if ((dbg_state inside {ST_INIT, ST_KSA, ST_PRGA}) &&
        (prev_state inside {ST_INIT, ST_KSA, ST_PRGA}) && key != prev_key)
      key_glitch = key_glitch + 1;
    prev_key   = key;
    prev_state = dbg_state;
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_vec = 0, n_err = 0;

  task automatic cfg_clear();
    for (int i = 0; i < 4; i++) begin
      bad_idx[i] = -1; bad_val[i] = 8'h00; race[i] = 1'b0; pat_sel[i] = 1'b0;
    end
    init_force = 1'b0; ksa_man_en = 1'b0; man_wren = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_search(input logic exp_found, input logic [KW-1:0] exp_key);
    exp_q.push_back({exp_found, exp_key});
    pulse_start();
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL busy_after_start: got %b want 1", busy);
    end
  endtask

  task automatic wait_result(input string name);
    logic [W-1:0] e;
    int cyc = 0;
    while (done_flag !== 1'b1 && cyc < BUDGET) begin
      @(negedge clk); cyc++;
    end
    e = exp_q.pop_front();
    n_vec++;
    if (done_flag !== 1'b1) begin
      n_err++; $display("FAIL %s_timeout: done_flag never rose in %0d cycles", name, BUDGET);
    end else if ({found, key} !== e || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_result: got found=%b key=%0d busy=%b want found=%b key=%0d busy=0",
               name, found, key, busy, e[W-1], e[KW-1:0]);
    end
  endtask

  task automatic wait_state(input state_e s, input logic [KW-1:0] k, input string name);
    int cyc = 0;
    while (!(dbg_state == s && key == k) && cyc < BUDGET) begin
      @(negedge clk); cyc++;
    end
    n_vec++;
    if (!(dbg_state == s && key == k)) begin
      n_err++; $display("FAIL %s_wait: state=%0d key=%0d want state=%0d key=%0d", name, dbg_state, key, s, k);
    end
  endtask

  task automatic check_arms(input string name, input int base_runs, input int base_bad, input int want);
    n_vec++;
    if (arm_runs - base_runs != want || bad_len != base_bad) begin
      n_err++;
      $display("FAIL %s_arm: got %0d ARM runs (%0d wrong length) want %0d runs of 2 cycles",
               name, arm_runs - base_runs, bad_len - base_bad, want);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({done_flag, found, busy, phase_rst_n, s_wren, init_start, ksa_start, prga_start} !== 8'b0 ||
        key !== '0 || s_addr !== 8'd0 || s_wrdata !== 8'd0 || dbg_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset_values: done=%b found=%b busy=%b prn=%b s_wren=%b key=%0d s_addr=%h st=%0d want all 0, IDLE",
               done_flag, found, busy, phase_rst_n, s_wren, key, s_addr, dbg_state);
    end
    reset = 1'b1;
    repeat (5) @(negedge clk);
    n_vec++;
    if (dbg_state !== ST_IDLE || busy !== 1'b0 || phase_rst_n !== 1'b1 || done_flag !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle_hold: st=%0d busy=%b prn=%b done=%b want IDLE,0,1,0", dbg_state, busy, phase_rst_n, done_flag);
    end
  endtask

  task automatic test_key0_good();
    int r0 = arm_runs, b0 = bad_len;
    cfg_clear();
    run_search(1'b1, 24'd0);
    wait_state(ST_INIT, 24'd0, "key0_init");
    pulse_start();  // must be ignored while busy
    wait_result("key0_good");
    check_arms("key0_good", r0, b0, 1);
  endtask

  task automatic test_reject_then_accept();
    int r0 = arm_runs, b0 = bad_len;
    cfg_clear();
    bad_idx[0] = 3; bad_val[0] = 8'h7B;
    pat_sel[1] = 1'b1;
    run_search(1'b1, 24'd1);
    wait_result("reject_accept");
    check_arms("reject_accept", r0, b0, 2);
  endtask

  task automatic test_race();
    int r0 = arm_runs, b0 = bad_len;
    cfg_clear();
    bad_idx[0] = PRGA_LEN - 1; bad_val[0] = 8'h41; race[0] = 1'b1;
    run_search(1'b1, 24'd1);
    wait_result("race");
    check_arms("race", r0, b0, 2);
  endtask

  task automatic test_exhaustion();
    int r0 = arm_runs, b0 = bad_len, g0 = key_glitch;
    cfg_clear();
    // characters just outside each edge of the accepted set
    bad_idx[0] = 0; bad_val[0] = 8'd96;
    bad_idx[1] = 0; bad_val[1] = 8'd123;
    bad_idx[2] = 0; bad_val[2] = 8'd31;
    bad_idx[3] = 0; bad_val[3] = 8'd33;
    run_search(1'b0, 24'd3);
    wait_result("exhaustion");
    check_arms("exhaustion", r0, b0, 4);
    n_vec++;
    if (key_glitch != g0) begin
      n_err++; $display("FAIL key_stable: got %0d key changes mid-key want 0", key_glitch - g0);
    end
  endtask

  task automatic test_mux_reset();
    int r0;
    cfg_clear();
    bad_idx[0] = 2; bad_val[0] = 8'h60;
    ksa_man_en = 1'b1; ksa_man_key = 24'd1;
    pulse_start();
    wait_state(ST_KSA, 24'd1, "mux_ksa");
    init_force = 1'b1;
    man_addr = 8'h55; man_wrdata = 8'h3C; man_wren = 1'b0;
    @(negedge clk);
    n_vec++;
    if (s_addr !== 8'h55 || s_wren !== 1'b0) begin
      n_err++; $display("FAIL mux_ksa_idle: s_addr=%h s_wren=%b want 55,0", s_addr, s_wren);
    end
    man_wren = 1'b1;
    @(negedge clk);
    n_vec++;
    if (s_addr !== 8'h55 || s_wren !== 1'b1 || s_wrdata !== 8'h3C) begin
      n_err++; $display("FAIL mux_ksa_write: s_addr=%h s_wren=%b s_wrdata=%h want 55,1,3c", s_addr, s_wren, s_wrdata);
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if (dbg_state !== ST_IDLE || key !== '0 || busy !== 1'b0 || phase_rst_n !== 1'b0 ||
        s_wren !== 1'b0 || s_addr !== 8'd0 || ksa_start !== 1'b0 || done_flag !== 1'b0) begin
      n_err++;
      $display("FAIL midksa_reset: st=%0d key=%0d busy=%b prn=%b s_wren=%b s_addr=%h ksa_start=%b want IDLE,0,0,0,0,00,0",
               dbg_state, key, busy, phase_rst_n, s_wren, s_addr, ksa_start);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cfg_clear();
    repeat (4) @(negedge clk);
    n_vec++;
    if (dbg_state !== ST_IDLE || busy !== 1'b0 || init_start !== 1'b0) begin
      n_err++; $display("FAIL no_resume: st=%0d busy=%b init_start=%b want IDLE,0,0", dbg_state, busy, init_start);
    end
    r0 = arm_runs;
    run_search(1'b1, 24'd0);
    wait_result("restart");
    check_arms("restart", r0, bad_len, 1);
  endtask

  task automatic test_restart_from_done();
    int r0 = arm_runs, b0 = bad_len;
    cfg_clear();
    bad_idx[0] = 5; bad_val[0] = 8'hFF;
    run_search(1'b1, 24'd1);
    @(negedge clk);
    n_vec++;
    if (done_flag !== 1'b0 || found !== 1'b0 || key !== 24'd0) begin
      n_err++; $display("FAIL restart_clear: done=%b found=%b key=%0d want 0,0,0", done_flag, found, key);
    end
    wait_result("restart_done");
    check_arms("restart_done", r0, b0, 2);
  endtask

  initial begin
    cfg_clear();
    test_reset();
    test_key0_good();
    test_reject_then_accept();
    test_race();
    test_exhaustion();
    test_restart_from_done();
    test_mux_reset();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: %0d results left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
